alarm_bank: RTL and testbench

- Multi-channel alarm unit for the clock design: N independently programmable, armable alarms sharing one set of edit buttons.
- Compares each armed alarm against the running time-of-day and drives a buzzer.
- Adds ring timeout, snooze with a repeat limit, and dismiss.
- Sits beside the timekeeping counter; its outputs feed the display mux and the buzzer pin.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_bank_btn_edge.sv | 19 +
 rtl/alarm_bank.sv | 182 ++++++++++++++++++
 tb/tb_alarm_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm unit.
package alarm_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HOUR = 2'd1,
    MIN  = 2'd2
  } field_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_e;

  localparam int HOURS_PER_DAY = 24;
  localparam int MINS_PER_HOUR = 60;

endpackage

// File: rtl/alarm_bank_btn_edge.sv
// Rising-edge pulse from a debounced button level; edge history clears on reset.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm: shared edit buttons, time-of-day match, ring/snooze/dismiss FSM.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter  int N_ALARMS    = 4,
  parameter  int RING_SECS   = 30,
  parameter  int SNOOZE_SECS = 300,
  parameter  int MAX_SNOOZE  = 3,
  localparam int IW          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sec_tick,
  input  logic [4:0]          hour,
  input  logic [5:0]          minute,
  input  logic [5:0]          second,
  input  logic                mode,
  input  logic                btn_mid,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_sel,
  output logic [IW-1:0]       sel_idx,
  output logic [1:0]          edit_field,
  output logic [4:0]          sel_hour,
  output logic [5:0]          sel_minute,
  output logic [N_ALARMS-1:0] armed,
  output logic [IW-1:0]       ring_idx,
  output logic                ringing,
  output logic                snoozing,
  output logic                buzzer
);

  localparam int RW = $clog2(RING_SECS) + 1;
  localparam int SW = $clog2(SNOOZE_SECS) + 1;
  localparam int NW = $clog2(MAX_SNOOZE) + 1;

  // ---- button edges: {sel, down, up, mid} ----
  logic [3:0] btn_lvl, btn_pls;
  logic       p_mid, p_up, p_down, p_sel, inc, dec;

  assign btn_lvl = {btn_sel, btn_down, btn_up, btn_mid};

  btn_edge u_edge [3:0] (
    .clk   (clk),
    .rst   (rst),
    .level (btn_lvl),
    .pulse (btn_pls)
  );

  assign {p_sel, p_down, p_up, p_mid} = btn_pls;
  // Simultaneous up+down cancels out
  assign inc = p_up & ~p_down;
  assign dec = p_down & ~p_up;

  // ---- per-channel storage ----
  logic [N_ALARMS-1:0][4:0] al_hour;
  logic [N_ALARMS-1:0][5:0] al_min;
  field_e                   field_q;

  assign edit_field = field_q;
  assign sel_hour   = al_hour[sel_idx];
  assign sel_minute = al_min[sel_idx];

  // Edit engine: field cycling, channel select, arm toggle, wrapping hour/minute
  always_ff @(posedge clk) begin
    if (rst) begin
      al_hour <= '0;
      al_min  <= '0;
      armed   <= '0;
      sel_idx <= '0;
      field_q <= NONE;
    end else if (!mode) begin
      field_q <= NONE;
    end else begin
      if (p_mid) begin
        case (field_q)
          NONE:    field_q <= HOUR;
          HOUR:    field_q <= MIN;
          default: field_q <= NONE;
        endcase
      end
      case (field_q)
        NONE: begin
          if (p_sel)
            sel_idx <= (sel_idx == IW'(N_ALARMS - 1)) ? '0 : sel_idx + IW'(1);
          if (inc) armed[sel_idx] <= ~armed[sel_idx];
        end
        HOUR: begin
          if (inc)
            al_hour[sel_idx] <= (al_hour[sel_idx] == 5'(HOURS_PER_DAY - 1)) ? '0
                                : al_hour[sel_idx] + 5'd1;
          else if (dec)
            al_hour[sel_idx] <= (al_hour[sel_idx] == '0) ? 5'(HOURS_PER_DAY - 1)
                                : al_hour[sel_idx] - 5'd1;
        end
        MIN: begin
          if (inc)
            al_min[sel_idx] <= (al_min[sel_idx] == 6'(MINS_PER_HOUR - 1)) ? '0
                               : al_min[sel_idx] + 6'd1;
          else if (dec)
            al_min[sel_idx] <= (al_min[sel_idx] == '0) ? 6'(MINS_PER_HOUR - 1)
                               : al_min[sel_idx] - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Lowest-index armed channel whose hour:minute equals the time of day
  logic          hit;
  logic [IW-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (armed[i] && al_hour[i] == hour && al_min[i] == minute) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // ---- ring FSM ----
  ring_e         state, nxt;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [NW-1:0] snz_num;
  logic          abort;

  // Edit mode, disarm of the active channel, or a dismiss all end the event
  assign abort = mode | ~armed[ring_idx] | p_mid;

  // Next-state decision; buttons outrank a same-cycle sec_tick
  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (!mode && sec_tick && second == '0 && hit) nxt = RING;
      RING:
        if (abort)                                        nxt = IDLE;
        else if (p_up)                                    nxt = (snz_num < NW'(MAX_SNOOZE)) ? SNOOZE : IDLE;
        else if (sec_tick && ring_cnt == RW'(RING_SECS - 1)) nxt = IDLE;
      SNOOZE:
        if (abort)                                        nxt = IDLE;
        else if (sec_tick && snz_cnt <= SW'(1))           nxt = RING;
      default:                                            nxt = IDLE;
    endcase
  end

  // State, counters and registered ring outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ring_idx <= '0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_num  <= '0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      state    <= nxt;
      ringing  <= (nxt == RING);
      snoozing <= (nxt == SNOOZE);
      buzzer   <= (nxt == RING) & ~second[0];
      if (state == IDLE && nxt == RING) begin
        ring_idx <= hit_idx;
        ring_cnt <= '0;
        snz_num  <= '0;
      end
      if (state == RING && nxt == RING && sec_tick) ring_cnt <= ring_cnt + RW'(1);
      if (state == RING && nxt == SNOOZE) begin
        snz_num <= snz_num + NW'(1);
        snz_cnt <= SW'(SNOOZE_SECS);
      end
      if (state == SNOOZE && nxt == SNOOZE && sec_tick) snz_cnt <= snz_cnt - SW'(1);
      if (state == SNOOZE && nxt == RING) ring_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expectations queued with stimulus, checked after each edge.
module tb_alarm_bank;

  logic       clk = 1'b0, rst = 1'b1, sec_tick = 1'b0, mode = 1'b0;
  logic       btn_mid = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0, second = '0;
  logic [1:0] sel_idx, edit_field, ring_idx;
  logic [4:0] sel_hour;
  logic [5:0] sel_minute;
  logic [3:0] armed;
  logic       ringing, snoozing, buzzer;

  alarm_bank dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .hour(hour), .minute(minute), .second(second), .mode(mode),
    .btn_mid(btn_mid), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .sel_idx(sel_idx), .edit_field(edit_field), .sel_hour(sel_hour), .sel_minute(sel_minute),
    .armed(armed), .ring_idx(ring_idx), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  localparam int F_ARM = 0, F_RING = 1, F_SNZ = 2, F_BUZ = 3, F_RIDX = 4,
                 F_SEL = 5, F_FLD = 6, F_HR = 7, F_MN = 8;
  localparam int B_MID = 0, B_UP = 1, B_DN = 2, B_SEL = 3;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    string       tag;
    int          fld;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int fld);
    case (fld)
      F_ARM:   return 32'(armed);
      F_RING:  return 32'(ringing);
      F_SNZ:   return 32'(snoozing);
      F_BUZ:   return 32'(buzzer);
      F_RIDX:  return 32'(ring_idx);
      F_SEL:   return 32'(sel_idx);
      F_FLD:   return 32'(edit_field);
      F_HR:    return 32'(sel_hour);
      default: return 32'(sel_minute);
    endcase
  endfunction

  task automatic want(input string tag, input int fld, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.fld = fld; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, obs_of(e.fld), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MID:   btn_mid  = v;
      B_UP:    btn_up   = v;
      B_DN:    btn_down = v;
      default: btn_sel  = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step();
    set_btn(b, 1'b0);
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h); minute = 6'(m); second = 6'(s);
  endtask

  // Advance the reference clock by one second and pulse sec_tick for one cycle
  task automatic tick();
    int h, m, s;
    h = int'(hour); m = int'(minute); s = int'(second) + 1;
    if (s == 60) begin s = 0; m++; end
    if (m == 60) begin m = 0; h++; end
    if (h == 24) h = 0;
    set_time(h, m, s);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic want_reset(input string pfx);
    want({pfx, "_arm"},  F_ARM,  0);
    want({pfx, "_ring"}, F_RING, 0);
    want({pfx, "_snz"},  F_SNZ,  0);
    want({pfx, "_buz"},  F_BUZ,  0);
    want({pfx, "_ridx"}, F_RIDX, 0);
    want({pfx, "_sel"},  F_SEL,  0);
    want({pfx, "_fld"},  F_FLD,  0);
    want({pfx, "_hr"},   F_HR,   0);
    want({pfx, "_mn"},   F_MN,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // reset state
    step();
    want_reset("rst");
    step();
    rst = 1'b0;
    step();

    // edit: channel 2 -> 23:01, then arm it
    mode = 1'b1;
    press(B_SEL);
    want("sel_2", F_SEL, 2);         press(B_SEL);
    want("fld_hour", F_FLD, 1);      press(B_MID);
    want("hr_wrap_dn", F_HR, 23);    press(B_DN);
    press(B_MID);
    want("min_inc", F_MN, 1);
    want("hr_no_carry", F_HR, 23);   press(B_UP);
    want("fld_none", F_FLD, 0);      press(B_MID);
    want("arm_ch2", F_ARM, 4'b0100); press(B_UP);

    // channel 2 -> 07:30 (hour wraps through 0)
    press(B_MID);
    repeat (7) press(B_UP);
    want("hr_wrap_up", F_HR, 7);     press(B_UP);
    press(B_MID);
    repeat (28) press(B_UP);
    want("min_730", F_MN, 30);       press(B_UP);
    press(B_MID);

    // channel select wraps 3 -> 0; minute wraps both ways
    press(B_SEL);
    want("sel_wrap", F_SEL, 0);      press(B_SEL);
    press(B_MID); press(B_MID);
    want("min_wrap_dn", F_MN, 59);   press(B_DN);
    want("min_wrap_up", F_MN, 0);    press(B_UP);
    btn_up = 1'b1; btn_down = 1'b1;
    want("updn_min", F_MN, 0);
    want("updn_hr", F_HR, 0);
    step();
    btn_up = 1'b0; btn_down = 1'b0;
    step();

    // leaving edit mode from HOUR forces NONE
    press(B_MID); press(B_MID);
    mode = 1'b0;
    want("leave_fld", F_FLD, 0);
    step();

    // match on channel 2 and ring timeout
    set_time(7, 29, 59);
    want("match_ring", F_RING, 1);
    want("match_ridx", F_RIDX, 2);
    want("match_buz", F_BUZ, 1);
    tick();
    for (int t = 1; t <= 30; t++) begin
      if (t == 1)  want("buz_odd", F_BUZ, 0);
      if (t == 2)  want("buz_even", F_BUZ, 1);
      if (t == 29) want("ring_29", F_RING, 1);
      if (t == 30) begin
        want("ring_timeout", F_RING, 0);
        want("buz_timeout", F_BUZ, 0);
      end
      tick();
    end

    // priority: channels 1 and 3 at 06:00
    mode = 1'b1;
    step();
    press(B_SEL); press(B_UP);
    press(B_MID); repeat (6) press(B_UP); press(B_MID); press(B_MID);
    press(B_SEL); press(B_SEL); press(B_UP);
    press(B_MID); repeat (5) press(B_UP);
    want("ch3_hr", F_HR, 6);         press(B_UP);
    press(B_MID);
    want("arm_1_2_3", F_ARM, 4'b1110); press(B_MID);
    mode = 1'b0;
    step();
    set_time(5, 59, 59);
    want("prio_ring", F_RING, 1);
    want("prio_ridx", F_RIDX, 1);
    tick();
    btn_mid = 1'b1; btn_up = 1'b1;
    want("midup_ring", F_RING, 0);
    want("midup_snz", F_SNZ, 0);
    step();
    btn_mid = 1'b0; btn_up = 1'b0;
    step();

    // snooze three times, fourth snooze press dismisses
    set_time(5, 59, 59);
    want("snz_start_ring", F_RING, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      want("snz_on", F_SNZ, 1);
      want("snz_ring_off", F_RING, 0);
      want("snz_buz_off", F_BUZ, 0);
      press(B_UP);
      repeat (298) tick();
      want("snz_hold", F_SNZ, 1);
      tick();
      want("rering", F_RING, 1);
      want("rering_snz", F_SNZ, 0);
      tick();
    end
    want("snz4_ring", F_RING, 0);
    want("snz4_snz", F_SNZ, 0);
    press(B_UP);

    // edit mode during RING aborts; channel stays armed
    set_time(5, 59, 59);
    want("abort_pre", F_RING, 1);
    tick();
    mode = 1'b1;
    want("abort_ring", F_RING, 0);
    want("abort_buz", F_BUZ, 0);
    want("abort_arm", F_ARM, 4'b1110);
    step();
    mode = 1'b0;
    step();

    // reset mid-snooze with btn_up held
    set_time(5, 59, 59);
    tick();
    want("pre_rst_snz", F_SNZ, 1);
    press(B_UP);
    btn_up = 1'b1;
    rst = 1'b1;
    step();
    want_reset("mid_rst");
    step();
    rst = 1'b0;
    want_reset("post_rst");
    step();
    btn_up = 1'b0;
    step();

    // disarmed channels never ring
    set_time(23, 59, 59);
    want("disarmed_ring", F_RING, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
